signed_divider_16x8: RTL and testbench

Iterative signed integer divider: 16-bit two's-complement dividend by 8-bit two's-complement divisor, producing a 16-bit quotient and an 8-bit remainder. It is the inverse companion of the 8x8 signed Booth multiplier in the multiplier library and serves the Posit FMAU's fraction-division and reciprocal-check paths. The core is a radix-2 restoring divider on magnitudes with sign fix-up, and it uses a valid/ready handshake on both the input and output sides.

---
 rtl/signed_divider_16x8.sv | 157 +++++++++++++++
 tb/tb_signed_divider_16x8.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider_16x8.sv
// Radix-2 restoring signed divider, 16-bit dividend by 8-bit divisor.
// Optional SDIV_EARLY_EXIT_EN: trivial operands skip the iteration loop.
module signed_divider_16x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [15:0] dvd_mag;
    logic [7:0]  dsr_mag;
    logic [7:0]  prem;
    logic [15:0] q_mag;
    logic [4:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        dz;
    logic        ov;

    logic        accept;
    logic        early;
    logic        is_dz;
    logic        is_ov;
    logic [15:0] dvd_abs;
    logic [7:0]  dsr_abs;
    logic [8:0]  rem_sh;
    logic        fits;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_dz    = (divisor == 8'h00);
    assign is_ov    = (dividend == 16'h8000) && (divisor == 8'hFF);

    // Unsigned 16 bits already hold 32768, the magnitude of -32768.
    assign dvd_abs = dividend[15] ? 16'd0 - dividend : dividend;
    assign dsr_abs = divisor[7] ? 8'd0 - divisor : divisor;

`ifdef SDIV_EARLY_EXIT_EN
    assign early = is_dz || is_ov || (dividend == 16'h0000);
`else
    assign early = 1'b0;
`endif

    assign rem_sh = {prem, dvd_mag[15]};
    assign fits   = (rem_sh >= {1'b0, dsr_mag});

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = early ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == 5'd15) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            quotient  <= 16'h0000;
            remainder <= 8'h00;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            dvd_mag   <= 16'h0000;
            dsr_mag   <= 8'h00;
            prem      <= 8'h00;
            q_mag     <= 16'h0000;
            cnt       <= 5'd0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz        <= 1'b0;
            ov        <= 1'b0;
        end else begin
            state     <= state_nx;
            // Result is presented the cycle after DONE is entered.
            out_valid <= (state == DONE) && !(out_valid && out_ready);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_mag <= dvd_abs;
                        dsr_mag <= dsr_abs;
                        q_neg   <= dividend[15] ^ divisor[7];
                        r_neg   <= dividend[15];
                        dz      <= is_dz;
                        ov      <= is_ov;
                        prem    <= 8'h00;
                        q_mag   <= 16'h0000;
                        cnt     <= 5'd0;
                    end
                end
                CALC: begin
                    cnt     <= cnt + 5'd1;
                    dvd_mag <= {dvd_mag[14:0], 1'b0};
                    q_mag   <= {q_mag[14:0], fits};
                    if (fits) begin
                        prem <= 8'(rem_sh - {1'b0, dsr_mag});
                    end else begin
                        prem <= rem_sh[7:0];
                    end
                end
                FIX: begin
                    div_zero <= dz;
                    overflow <= ov && !dz;
                    if (dz) begin
                        quotient  <= r_neg ? 16'h8000 : 16'h7FFF;
                        remainder <= 8'h00;
                    end else if (ov) begin
                        quotient  <= 16'h8000;
                        remainder <= 8'h00;
                    end else begin
                        quotient  <= q_neg ? 16'd0 - q_mag : q_mag;
                        remainder <= r_neg ? 8'd0 - prem : prem;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_16x8.sv
// Self-checking bench for signed_divider_16x8: directed boundary cases
// plus randomized operands against an integer-arithmetic reference.
module tb_signed_divider_16x8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = 16'h0000;
    logic [7:0]  divisor = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        overflow;

    int n_cmp = 0;
    int n_fail = 0;

`ifdef SDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    signed_divider_16x8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    // Reference: {quotient, remainder, div_zero, overflow}
    function automatic logic [25:0] model(input int a, input int b);
        logic [15:0] q;
        logic [7:0]  r;
        if (b == 0) begin
            q = (a >= 0) ? 16'h7FFF : 16'h8000;
            return {q, 8'h00, 1'b1, 1'b0};
        end
        if (a == -32768 && b == -1) begin
            return {16'h8000, 8'h00, 1'b0, 1'b1};
        end
        q = 16'(a / b);
        r = 8'(a % b);
        return {q, r, 2'b00};
    endfunction

    function automatic int model_lat(input int a, input int b);
        if (EARLY && (b == 0 || a == 0 || (a == -32768 && b == -1)))
            return 2;
        return 18;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output logic [25:0] got, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = {quotient, remainder, div_zero, overflow};
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_zero, overflow}
            !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [25:0] got;
        int lat;
        run_op(16'd100, 8'd7, got, lat);
        n_cmp++;
        if (got !== {16'd14, 8'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL basic 100/7: got %h want %h", got, {16'd14, 8'd2, 2'b00});
        end
        n_cmp++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL basic latency: got %0d want 18", lat);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_signs();
        int          ta[4] = '{-100, 100, -100, 0};
        int          tb[4] = '{7, -7, -7, 5};
        logic [15:0] tq[4] = '{16'hFFF2, 16'hFFF2, 16'h000E, 16'h0000};
        logic [7:0]  tr[4] = '{8'hFE, 8'h02, 8'hFE, 8'h00};
        logic [25:0] got;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(16'(ta[i]), 8'(tb[i]), got, lat);
            n_cmp++;
            if (got !== {tq[i], tr[i], 2'b00}) begin
                n_fail++;
                $display("FAIL signs %0d/%0d: got %h want %h", ta[i], tb[i], got, {tq[i], tr[i], 2'b00});
            end
            n_cmp++;
            if (lat !== model_lat(ta[i], tb[i])) begin
                n_fail++;
                $display("FAIL signs latency %0d/%0d: got %0d want %0d", ta[i], tb[i], lat, model_lat(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_overflow();
        int          ta[3] = '{-32768, -32768, -32768};
        int          tb[3] = '{-1, -128, 1};
        logic [25:0] te[3] = '{{16'h8000, 8'h00, 2'b01},
                               {16'h0100, 8'h00, 2'b00},
                               {16'h8000, 8'h00, 2'b00}};
        logic [25:0] got;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(16'(ta[i]), 8'(tb[i]), got, lat);
            n_cmp++;
            if (got !== te[i]) begin
                n_fail++;
                $display("FAIL overflow %0d/%0d: got %h want %h", ta[i], tb[i], got, te[i]);
            end
            n_cmp++;
            if (lat !== model_lat(ta[i], tb[i])) begin
                n_fail++;
                $display("FAIL overflow latency %0d/%0d: got %0d want %0d", ta[i], tb[i], lat, model_lat(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_div_zero();
        int          ta[3] = '{1234, -5, 0};
        logic [25:0] te[3] = '{{16'h7FFF, 8'h00, 2'b10},
                               {16'h8000, 8'h00, 2'b10},
                               {16'h7FFF, 8'h00, 2'b10}};
        logic [25:0] got;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(16'(ta[i]), 8'h00, got, lat);
            n_cmp++;
            if (got !== te[i]) begin
                n_fail++;
                $display("FAIL div_zero %0d/0: got %h want %h", ta[i], got, te[i]);
            end
            n_cmp++;
            if (lat !== (EARLY ? 2 : 18)) begin
                n_fail++;
                $display("FAIL div_zero latency %0d/0: got %0d want %0d", ta[i], lat, EARLY ? 2 : 18);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  b;
        logic [25:0] got;
        logic [25:0] exp;
        int lat;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 9) == 0) b = 8'h00;
            if ($urandom_range(0, 9) == 0) a = 16'h0000;
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            if ($urandom_range(0, 9) == 0) b = 8'h80;
            exp = model(int'($signed(a)), int'($signed(b)));
            run_op(a, b, got, lat);
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random %0d/%0d: got %h want %h", $signed(a), $signed(b), got, exp);
            end
            n_cmp++;
            if (lat !== model_lat(int'($signed(a)), int'($signed(b)))) begin
                n_fail++;
                $display("FAIL random latency %0d/%0d: got %0d", $signed(a), $signed(b), lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] snap;
        int wait_cyc;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'hF7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 100) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        snap = {quotient, remainder, div_zero, overflow};
        n_cmp++;
        if (snap !== {16'hFF91, 8'h01, 2'b00}) begin
            n_fail++;
            $display("FAIL backpressure value: got %h want %h", snap, {16'hFF91, 8'h01, 2'b00});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({quotient, remainder, div_zero, overflow, out_valid, in_ready}
                !== {snap, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure hold %0d: got %h vld=%b rdy=%b want %h 1 0",
                         i, {quotient, remainder, div_zero, overflow}, out_valid, in_ready, snap);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] got;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd12345;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_zero, overflow}
            !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd7, 8'd2, got, lat);
        n_cmp++;
        if (got !== {16'd3, 8'd1, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid 7/2: got %h want %h", got, {16'd3, 8'd1, 2'b00});
        end
        n_cmp++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL reset_mid latency: got %0d want 18", lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
